// File: rtl/proc_ctrl_pkg.sv
// Shared definitions for the multi-cycle instruction sequencer:
// state encoding, instruction class codes, HALT opcode and store-bit position.
package proc_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_RST    = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6
  } state_e;

  typedef enum logic [1:0] {
    CLS_ALU_REG = 2'b00,
    CLS_ALU_IMM = 2'b01,
    CLS_MEM     = 2'b10,
    CLS_BRANCH  = 2'b11
  } op_class_e;

  localparam logic [7:0] OP_HALT   = 8'hFF;
  // bit position of the store flag within an 8-bit opcode
  localparam int         STORE_BIT = 5;

  // instruction class lives in the two MSBs of the opcode
  function automatic op_class_e op_class(input logic [1:0] msbs);
    return op_class_e'(msbs);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Memory-wait watchdog: down-counter reloaded to TIMEOUT_CYC whenever the
// sequencer is not waiting (or sees its ack), decremented on each wait cycle
// without ack. expired_o flags terminal count. Only built when MEM_TIMEOUT_EN
// is defined.
`ifdef MEM_TIMEOUT_EN
module mem_wait_timer #(
  parameter int TIMEOUT_CYC = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  input  logic run_i,
  output logic expired_o
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  logic [CW-1:0] cnt_q;

  // reload outside a wait, count down while waiting, stick at zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= CW'(TIMEOUT_CYC);
    end else if (load_i) begin
      cnt_q <= CW'(TIMEOUT_CYC);
    end else if (run_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CW'(1);
    end
  end

  assign expired_o = (cnt_q == '0);

endmodule
`endif

// File: rtl/multicycle_seq_ctrl.sv
// Multi-cycle sequencer: walks each instruction through FETCH/DECODE/EXEC/MEM/WB
// and drives the PC, IR, register-file and memory enables, stalling on
// variable-latency instruction/data memory acks.
// Optional feature: define MEM_TIMEOUT_EN to bound memory waits to TIMEOUT_CYC
// cycles; on expiry the request drops, bus_err and halted set, and the
// sequencer parks in HALT.
//
//  state  | meaning
//  RST    | one idle cycle after reset, no requests
//  FETCH  | imem_req held until imem_ack; ack cycle latches IR and bumps PC
//  DECODE | one cycle; HALT opcode parks the core
//  EXEC   | ALU ops go to WB, memory ops to MEM, branches retire here
//  MEM    | dmem_req (dmem_we for stores) held until dmem_ack
//  WB     | one-cycle register-file write, retire
//  HALT   | terminal until reset
module multicycle_seq_ctrl #(
  parameter int OPBITS      = 8,
  parameter int RETIRE_W    = 32,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPBITS-1:0]   opcode,
  input  logic                br_taken,
  input  logic                imem_ack,
  input  logic                dmem_ack,
  output logic                imem_req,
  output logic                dmem_req,
  output logic                dmem_we,
  output logic                ir_we,
  output logic                pc_inc,
  output logic                pc_ld,
  output logic                rf_we,
  output logic                alu_src_imm,
  output logic                halted,
  output logic                bus_err,
  output logic [RETIRE_W-1:0] retired
);
  import proc_ctrl_pkg::*;

  // store flag position scales with opcode width (class bits stay at the top)
  localparam int STORE_IDX = OPBITS - 8 + STORE_BIT;

  state_e              state_q, state_d;
  logic                halted_q;
  logic                bus_err_q;
  logic [RETIRE_W-1:0] retired_q;
  logic                retire;
  logic                tmo_hit;
  logic                tmo_expired;
  op_class_e           cls;
  logic                is_store;
  logic                is_halt;

  assign cls      = op_class(opcode[OPBITS-1 -: 2]);
  assign is_store = opcode[STORE_IDX];
  assign is_halt  = (opcode == OPBITS'(OP_HALT));

`ifdef MEM_TIMEOUT_EN
  logic wait_st;
  logic acked;

  assign wait_st = (state_q == ST_FETCH) || (state_q == ST_MEM);
  assign acked   = ((state_q == ST_FETCH) && imem_ack) ||
                   ((state_q == ST_MEM)   && dmem_ack);

  mem_wait_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_wait_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (!wait_st || acked),
    .run_i     (wait_st && !acked),
    .expired_o (tmo_expired)
  );
`else
  logic unused_timeout;
  assign unused_timeout = |TIMEOUT_CYC;
  assign tmo_expired    = 1'b0;
`endif

  // next state plus combinational datapath enables decoded from state/opcode/acks
  always_comb begin
    state_d     = state_q;
    imem_req    = 1'b0;
    dmem_req    = 1'b0;
    dmem_we     = 1'b0;
    ir_we       = 1'b0;
    pc_inc      = 1'b0;
    pc_ld       = 1'b0;
    rf_we       = 1'b0;
    alu_src_imm = 1'b0;
    retire      = 1'b0;
    tmo_hit     = 1'b0;
    unique case (state_q)
      ST_RST: begin
        state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (tmo_expired) begin
          tmo_hit = 1'b1;
          state_d = ST_HALT;
        end else begin
          imem_req = 1'b1;
          if (imem_ack) begin
            ir_we   = 1'b1;
            pc_inc  = 1'b1;
            state_d = ST_DECODE;
          end
        end
      end
      ST_DECODE: begin
        state_d = is_halt ? ST_HALT : ST_EXEC;
      end
      ST_EXEC: begin
        alu_src_imm = (cls == CLS_ALU_IMM) || (cls == CLS_MEM);
        unique case (cls)
          CLS_ALU_REG, CLS_ALU_IMM: state_d = ST_WB;
          CLS_MEM:                  state_d = ST_MEM;
          default: begin
            pc_ld   = br_taken;
            retire  = 1'b1;
            state_d = ST_FETCH;
          end
        endcase
      end
      ST_MEM: begin
        alu_src_imm = (cls == CLS_ALU_IMM) || (cls == CLS_MEM);
        if (tmo_expired) begin
          tmo_hit = 1'b1;
          state_d = ST_HALT;
        end else begin
          dmem_req = 1'b1;
          dmem_we  = is_store;
          if (dmem_ack) begin
            if (is_store) begin
              retire  = 1'b1;
              state_d = ST_FETCH;
            end else begin
              state_d = ST_WB;
            end
          end
        end
      end
      ST_WB: begin
        rf_we   = 1'b1;
        retire  = 1'b1;
        state_d = ST_FETCH;
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_RST;
      end
    endcase
  end

  // state register and the registered status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_RST;
      halted_q  <= 1'b0;
      bus_err_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_d == ST_HALT) begin
        halted_q <= 1'b1;
      end
      if (tmo_hit) begin
        bus_err_q <= 1'b1;
      end
      if (retire) begin
        retired_q <= retired_q + RETIRE_W'(1);
      end
    end
  end

  assign halted  = halted_q;
  assign bus_err = bus_err_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_seq_ctrl.sv
// Directed bench for multicycle_seq_ctrl. Control outputs are compared each
// cycle as one vector:
//   {imem_req, dmem_req, dmem_we, ir_we, pc_inc, pc_ld, rf_we, alu_src_imm, halted, bus_err}
// A narrow retire counter is used so wrap-around is reachable.
module tb_multicycle_seq_ctrl;

  localparam int RW  = 4;
  localparam int TMO = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [7:0]    opcode;
  logic          br_taken;
  logic          imem_ack;
  logic          dmem_ack;
  logic          imem_req, dmem_req, dmem_we, ir_we, pc_inc, pc_ld;
  logic          rf_we, alu_src_imm, halted, bus_err;
  logic [RW-1:0] retired;
  logic [9:0]    ctl;

  int errors  = 0;
  int checks  = 0;
  int exp_ret = 0;

  multicycle_seq_ctrl #(
    .OPBITS      (8),
    .RETIRE_W    (RW),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .opcode      (opcode),
    .br_taken    (br_taken),
    .imem_ack    (imem_ack),
    .dmem_ack    (dmem_ack),
    .imem_req    (imem_req),
    .dmem_req    (dmem_req),
    .dmem_we     (dmem_we),
    .ir_we       (ir_we),
    .pc_inc      (pc_inc),
    .pc_ld       (pc_ld),
    .rf_we       (rf_we),
    .alu_src_imm (alu_src_imm),
    .halted      (halted),
    .bus_err     (bus_err),
    .retired     (retired)
  );

  assign ctl = {imem_req, dmem_req, dmem_we, ir_we, pc_inc, pc_ld,
                rf_we, alu_src_imm, halted, bus_err};

  always #5 clk = ~clk;

  // advance to just after the next rising edge
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  // reset, release into the RST cycle, then step into FETCH
  task automatic apply_reset();
    rst_n = 1'b0;
    {imem_ack, dmem_ack, br_taken} = 3'b000;
    cyc();
    cyc();
    rst_n = 1'b1;
    cyc();
    exp_ret = 0;
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    opcode = 8'h00;
    {imem_ack, dmem_ack, br_taken} = 3'b100;
    cyc();
    #1;
    checks++;
    if (ctl !== 10'b0) begin
      errors++; $display("FAIL reset_ctl: got %b want %b", ctl, 10'b0);
    end
    checks++;
    if (retired !== RW'(0)) begin
      errors++; $display("FAIL reset_retired: got %0d want 0", retired);
    end
    cyc();
    rst_n = 1'b1;
    #1;
    checks++;
    if (ctl !== 10'b0) begin
      errors++; $display("FAIL rst_state_idle: got %b want %b", ctl, 10'b0);
    end
    cyc();
    imem_ack = 1'b0;
    #1;
    checks++;
    if (ctl !== 10'b1000000000) begin
      errors++; $display("FAIL rst_to_fetch: got %b want %b", ctl, 10'b1000000000);
    end
    exp_ret = 0;
  endtask

  task automatic test_alu_reg();
    logic [2:0] stim [4] = '{3'b100, 3'b000, 3'b000, 3'b000};
    logic [9:0] expv [4] = '{10'b1001100000, 10'b0000000000,
                             10'b0000000000, 10'b0000001000};
    opcode = 8'h00;
    for (int i = 0; i < 4; i++) begin
      {imem_ack, dmem_ack, br_taken} = stim[i];
      #1;
      checks++;
      if (ctl !== expv[i]) begin
        errors++; $display("FAIL alu_reg_c%0d: got %b want %b", i, ctl, expv[i]);
      end
      cyc();
    end
    exp_ret++;
    {imem_ack, dmem_ack, br_taken} = 3'b000;
    #1;
    checks++;
    if (retired !== RW'(exp_ret)) begin
      errors++; $display("FAIL alu_reg_retired: got %0d want %0d", retired, RW'(exp_ret));
    end
    checks++;
    if (ctl !== 10'b1000000000) begin
      errors++; $display("FAIL alu_reg_refetch: got %b want %b", ctl, 10'b1000000000);
    end
  endtask

  task automatic test_alu_imm();
    logic [2:0] stim [6] = '{3'b000, 3'b000, 3'b100, 3'b000, 3'b000, 3'b000};
    logic [9:0] expv [6] = '{10'b1000000000, 10'b1000000000, 10'b1001100000,
                             10'b0000000000, 10'b0000000100, 10'b0000001000};
    opcode = 8'h41;
    for (int i = 0; i < 6; i++) begin
      {imem_ack, dmem_ack, br_taken} = stim[i];
      #1;
      checks++;
      if (ctl !== expv[i]) begin
        errors++; $display("FAIL alu_imm_c%0d: got %b want %b", i, ctl, expv[i]);
      end
      cyc();
    end
    exp_ret++;
    {imem_ack, dmem_ack, br_taken} = 3'b000;
    #1;
    checks++;
    if (retired !== RW'(exp_ret)) begin
      errors++; $display("FAIL alu_imm_retired: got %0d want %0d", retired, RW'(exp_ret));
    end
  endtask

  // stray dmem_ack in EXEC and stray imem_ack in MEM must be ignored
  task automatic test_load();
    logic [2:0] stim [8] = '{3'b100, 3'b000, 3'b010, 3'b100,
                             3'b000, 3'b000, 3'b010, 3'b000};
    logic [9:0] expv [8] = '{10'b1001100000, 10'b0000000000, 10'b0000000100,
                             10'b0100000100, 10'b0100000100, 10'b0100000100,
                             10'b0100000100, 10'b0000001000};
    opcode = 8'h80;
    for (int i = 0; i < 8; i++) begin
      {imem_ack, dmem_ack, br_taken} = stim[i];
      #1;
      checks++;
      if (ctl !== expv[i]) begin
        errors++; $display("FAIL load_c%0d: got %b want %b", i, ctl, expv[i]);
      end
      cyc();
    end
    exp_ret++;
    {imem_ack, dmem_ack, br_taken} = 3'b000;
    #1;
    checks++;
    if (retired !== RW'(exp_ret)) begin
      errors++; $display("FAIL load_retired: got %0d want %0d", retired, RW'(exp_ret));
    end
    checks++;
    if (ctl !== 10'b1000000000) begin
      errors++; $display("FAIL load_refetch: got %b want %b", ctl, 10'b1000000000);
    end
  endtask

  task automatic test_store();
    logic [2:0] stim [5] = '{3'b100, 3'b000, 3'b000, 3'b000, 3'b010};
    logic [9:0] expv [5] = '{10'b1001100000, 10'b0000000000, 10'b0000000100,
                             10'b0110000100, 10'b0110000100};
    opcode = 8'hA0;
    for (int i = 0; i < 5; i++) begin
      {imem_ack, dmem_ack, br_taken} = stim[i];
      #1;
      checks++;
      if (ctl !== expv[i]) begin
        errors++; $display("FAIL store_c%0d: got %b want %b", i, ctl, expv[i]);
      end
      cyc();
    end
    exp_ret++;
    {imem_ack, dmem_ack, br_taken} = 3'b000;
    #1;
    checks++;
    if (ctl !== 10'b1000000000) begin
      errors++; $display("FAIL store_refetch: got %b want %b", ctl, 10'b1000000000);
    end
    checks++;
    if (retired !== RW'(exp_ret)) begin
      errors++; $display("FAIL store_retired: got %0d want %0d", retired, RW'(exp_ret));
    end
  endtask

  // taken then not-taken; br_taken high in DECODE must not leak into pc_ld
  task automatic test_branch();
    logic [2:0] stim [6] = '{3'b100, 3'b000, 3'b001, 3'b100, 3'b001, 3'b000};
    logic [9:0] expv [6] = '{10'b1001100000, 10'b0000000000, 10'b0000010000,
                             10'b1001100000, 10'b0000000000, 10'b0000000000};
    opcode = 8'hC0;
    for (int i = 0; i < 6; i++) begin
      {imem_ack, dmem_ack, br_taken} = stim[i];
      #1;
      checks++;
      if (ctl !== expv[i]) begin
        errors++; $display("FAIL branch_c%0d: got %b want %b", i, ctl, expv[i]);
      end
      cyc();
    end
    exp_ret += 2;
    {imem_ack, dmem_ack, br_taken} = 3'b000;
    #1;
    checks++;
    if (retired !== RW'(exp_ret)) begin
      errors++; $display("FAIL branch_retired: got %0d want %0d", retired, RW'(exp_ret));
    end
  endtask

  // zero-wait stores and branches back to back; retire counter wraps
  task automatic test_back_to_back();
    opcode = 8'hA0;
    for (int n = 0; n < 4; n++) begin
      for (int i = 0; i < 4; i++) begin
        {imem_ack, dmem_ack, br_taken} = (i == 0) ? 3'b100 : ((i == 3) ? 3'b010 : 3'b000);
        cyc();
      end
      exp_ret++;
    end
    #1;
    checks++;
    if (ctl !== 10'b1000000000) begin
      errors++; $display("FAIL b2b_store_refetch: got %b want %b", ctl, 10'b1000000000);
    end
    checks++;
    if (retired !== RW'(exp_ret)) begin
      errors++; $display("FAIL b2b_store_retired: got %0d want %0d", retired, RW'(exp_ret));
    end
    opcode = 8'hC0;
    for (int n = 0; n < 14; n++) begin
      for (int i = 0; i < 3; i++) begin
        {imem_ack, dmem_ack, br_taken} = (i == 0) ? 3'b100 : 3'b000;
        cyc();
      end
      exp_ret++;
    end
    {imem_ack, dmem_ack, br_taken} = 3'b000;
    #1;
    checks++;
    if (retired !== RW'(exp_ret)) begin
      errors++; $display("FAIL b2b_wrap_retired: got %0d want %0d", retired, RW'(exp_ret));
    end
  endtask

  task automatic test_reset_mid_wait();
    opcode = 8'h80;
    {imem_ack, dmem_ack, br_taken} = 3'b100;
    cyc();
    {imem_ack, dmem_ack, br_taken} = 3'b000;
    cyc();
    cyc();
    #1;
    checks++;
    if (ctl !== 10'b0100000100) begin
      errors++; $display("FAIL midmem_waiting: got %b want %b", ctl, 10'b0100000100);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (ctl !== 10'b0) begin
      errors++; $display("FAIL midmem_reset_ctl: got %b want %b", ctl, 10'b0);
    end
    checks++;
    if (retired !== RW'(0)) begin
      errors++; $display("FAIL midmem_reset_retired: got %0d want 0", retired);
    end
    apply_reset();
    #1;
    checks++;
    if (imem_req !== 1'b1) begin
      errors++; $display("FAIL midfetch_req: got %b want 1", imem_req);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (imem_req !== 1'b0) begin
      errors++; $display("FAIL midfetch_reset_req: got %b want 0", imem_req);
    end
    apply_reset();
  endtask

`ifdef MEM_TIMEOUT_EN
  task automatic test_timeout();
    opcode = 8'h00;
    {imem_ack, dmem_ack, br_taken} = 3'b000;
    for (int i = 0; i < TMO + 4; i++) begin
      logic [9:0] want;
      want = (i < TMO) ? 10'b1000000000 : ((i == TMO) ? 10'b0000000000 : 10'b0000000011);
      if (i > TMO) imem_ack = 1'b1;
      #1;
      checks++;
      if (ctl !== want) begin
        errors++; $display("FAIL timeout_c%0d: got %b want %b", i, ctl, want);
      end
      cyc();
    end
    apply_reset();
    #1;
    checks++;
    if (ctl !== 10'b1000000000) begin
      errors++; $display("FAIL timeout_reset_clear: got %b want %b", ctl, 10'b1000000000);
    end
  endtask
`else
  task automatic test_unbounded_wait();
    opcode = 8'h00;
    {imem_ack, dmem_ack, br_taken} = 3'b000;
    for (int i = 0; i < 20; i++) begin
      #1;
      checks++;
      if (ctl !== 10'b1000000000) begin
        errors++; $display("FAIL unbounded_c%0d: got %b want %b", i, ctl, 10'b1000000000);
      end
      cyc();
    end
    apply_reset();
  endtask
`endif

  task automatic test_halt();
    logic [2:0] stim [2] = '{3'b100, 3'b000};
    logic [9:0] expv [2] = '{10'b1001100000, 10'b0000000000};
    opcode = 8'hFF;
    for (int i = 0; i < 2; i++) begin
      {imem_ack, dmem_ack, br_taken} = stim[i];
      #1;
      checks++;
      if (ctl !== expv[i]) begin
        errors++; $display("FAIL halt_c%0d: got %b want %b", i, ctl, expv[i]);
      end
      cyc();
    end
    {imem_ack, dmem_ack, br_taken} = 3'b110;
    for (int i = 0; i < 100; i++) begin
      #1;
      checks++;
      if (ctl !== 10'b0000000010) begin
        errors++; $display("FAIL halt_hold_c%0d: got %b want %b", i, ctl, 10'b0000000010);
      end
      cyc();
    end
    checks++;
    if (retired !== RW'(exp_ret)) begin
      errors++; $display("FAIL halt_retired: got %0d want %0d", retired, RW'(exp_ret));
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (ctl !== 10'b0) begin
      errors++; $display("FAIL halt_reset_ctl: got %b want %b", ctl, 10'b0);
    end
    {imem_ack, dmem_ack, br_taken} = 3'b000;
    cyc();
    rst_n = 1'b1;
    #1;
    checks++;
    if (ctl !== 10'b0) begin
      errors++; $display("FAIL halt_rst_state: got %b want %b", ctl, 10'b0);
    end
    cyc();
    #1;
    checks++;
    if (ctl !== 10'b1000000000) begin
      errors++; $display("FAIL halt_refetch: got %b want %b", ctl, 10'b1000000000);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  initial begin
    rst_n    = 1'b0;
    opcode   = 8'h00;
    br_taken = 1'b0;
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    test_reset();
    test_alu_reg();
    test_alu_imm();
    test_load();
    test_store();
    test_branch();
    test_back_to_back();
    test_reset_mid_wait();
`ifdef MEM_TIMEOUT_EN
    test_timeout();
`else
    test_unbounded_wait();
`endif
    test_halt();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
